hilo_mac_unit: RTL and testbench

Parametrised multi-cycle multiply/accumulate unit that owns the HI/LO register pair for the processor. It replaces the single-cycle combinational multiplier with an iterative shift-add engine. It supports signed and unsigned multiply, multiply-add, multiply-subtract and direct HI/LO writes. While it works, it raises `busy` so the core can freeze the PC.

---
 rtl/hilo_mac_pkg.sv | 29 ++
 rtl/hilo_mac_unit_mul_shift_add.sv | 52 +++++
 rtl/hilo_mac_unit.sv | 123 ++++++++++++
 tb/tb_hilo_mac_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hilo_mac_pkg.sv
// Shared types and op-decode helpers for the HI/LO multiply/accumulate unit.
package hilo_mac_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULU  = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    function automatic logic is_signed(input op_e op);
        return (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_acc(input op_e op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/hilo_mac_unit_mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step, LSB first.
module mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     sum;

    // Low half of the partial product starts as the multiplier and is consumed as it shifts out.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        if (load) begin
            mcand_d = mcand_in;
            prod_d  = {{WIDTH{1'b0}}, mplier_in};
            cnt_d   = '0;
        end else if (step) begin
            prod_d = prod_q[0] ? {sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last    = (cnt_q == CNT_W'(WIDTH - 1));
    assign product = prod_q;

endmodule

// File: rtl/hilo_mac_unit.sv
// HI/LO owner: sequences the shift-add multiplier and applies sign, accumulate and direct writes.
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO complete here
// CALC    | one multiplier bit per cycle
// FIN     | negate/accumulate and write HI/LO
module hilo_mac_unit
    import hilo_mac_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               load, step, last;
    logic [2*WIDTH-1:0] product, prod_s, acc, result;
    logic [WIDTH-1:0]   mag_a, mag_b;
    op_e                op_in;
    logic               signed_in;

    assign op_in     = op_e'(op);
    assign signed_in = is_signed(op_in);
    // Most-negative input maps to 2^(WIDTH-1), which fits unsigned, so no special case.
    assign mag_a = (signed_in && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign mag_b = (signed_in && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    mul_shift_add #(.WIDTH(WIDTH)) u_msa (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .mcand_in  (mag_a),
        .mplier_in (mag_b),
        .last      (last),
        .product   (product)
    );

    always_comb begin
        prod_s = sign_q ? (~product + (2*WIDTH)'(1)) : product;
        acc    = {hi_q, lo_q};
        result = prod_s;
        if (is_acc(op_q)) begin
            if (op_q == OP_MSUB || op_q == OP_MSUBU) result = acc - prod_s;
            else                                     result = acc + prod_s;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_in)
                        OP_MTHI: begin hi_d = a; done_d = 1'b1; end
                        OP_MTLO: begin lo_d = a; done_d = 1'b1; end
                        default: begin
                            load    = 1'b1;
                            op_d    = op_in;
                            sign_d  = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                            state_d = ST_CALC;
                        end
                    endcase
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (last) state_d = ST_FIN;
            end
            ST_FIN: begin
                {hi_d, lo_d} = result;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mac_unit.sv
// Directed vector bench for hilo_mac_unit at WIDTH=32 with hand-computed results.
module tb_hilo_mac_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl [0:14];

    hilo_mac_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and follow it to done; caller sits at #1 after a posedge.
    task automatic run_op(input vec_t v, input int idx);
        int cyc;
        int busy_cnt;
        int exp_lat;
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        exp_lat  = (v.op < 3'd6) ? W + 1 : 0;
        busy_cnt = busy ? 1 : 0;
        cyc      = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_cnt++;
        end
        chk($sformatf("latency[%0d]", idx), 64'(cyc), 64'(exp_lat));
        chk($sformatf("busy_cycles[%0d]", idx), 64'(busy_cnt), 64'(exp_lat));
        chk($sformatf("hi[%0d]", idx), 64'(hi), 64'(v.hi));
        chk($sformatf("lo[%0d]", idx), 64'(lo), 64'(v.lo));
        @(posedge clk); #1;
        chk($sformatf("done_pulse[%0d]", idx), 64'(done), 64'd0);
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;

        tbl[0]  = '{op: 3'd1, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001};
        tbl[1]  = '{op: 3'd0, a: 32'hFFFFFFFD, b: 32'h00000007, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB};
        tbl[2]  = '{op: 3'd0, a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000};
        tbl[3]  = '{op: 3'd6, a: 32'h00000005, b: 32'h00000000, hi: 32'h00000005, lo: 32'h00000000};
        tbl[4]  = '{op: 3'd7, a: 32'h0000000A, b: 32'h00000000, hi: 32'h00000005, lo: 32'h0000000A};
        tbl[5]  = '{op: 3'd2, a: 32'h00000002, b: 32'h00000003, hi: 32'h00000005, lo: 32'h00000010};
        tbl[6]  = '{op: 3'd4, a: 32'h00000004, b: 32'h00000004, hi: 32'h00000005, lo: 32'h00000000};
        tbl[7]  = '{op: 3'd6, a: 32'h00000000, b: 32'h00000000, hi: 32'h00000000, lo: 32'h00000000};
        tbl[8]  = '{op: 3'd7, a: 32'hFFFFFFFF, b: 32'h00000000, hi: 32'h00000000, lo: 32'hFFFFFFFF};
        tbl[9]  = '{op: 3'd3, a: 32'h00000001, b: 32'h00000001, hi: 32'h00000001, lo: 32'h00000000};
        tbl[10] = '{op: 3'd5, a: 32'h00000001, b: 32'h00000002, hi: 32'h00000000, lo: 32'hFFFFFFFE};
        tbl[11] = '{op: 3'd0, a: 32'hFFFFFFFF, b: 32'h00000001, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFF};
        tbl[12] = '{op: 3'd1, a: 32'h12345678, b: 32'h00000010, hi: 32'h00000001, lo: 32'h23456780};
        tbl[13] = '{op: 3'd4, a: 32'hFFFFFFFE, b: 32'h00000003, hi: 32'h00000001, lo: 32'h23456786};
        tbl[14] = '{op: 3'd2, a: 32'h7FFFFFFF, b: 32'h80000000, hi: 32'hC0000001, lo: 32'hA3456786};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        for (int i = 0; i < 15; i++) run_op(tbl[i], i);

        // MTHI then MTLO on consecutive cycles, no gap.
        start = 1'b1; op = 3'd6; a = 32'h5;
        @(posedge clk); #1;
        op = 3'd7; a = 32'hA;
        chk("b2b_done1", 64'(done), 64'd1);
        chk("b2b_hi1", 64'(hi), 64'h5);
        chk("b2b_busy1", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done2", 64'(done), 64'd1);
        chk("b2b_hi2", 64'(hi), 64'h5);
        chk("b2b_lo2", 64'(lo), 64'hA);
        chk("b2b_busy2", 64'(busy), 64'd0);

        // MTHI pulsed while busy must be ignored.
        start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin start = 1'b1; op = 3'd6; a = 32'hAA; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        start = 1'b0;
        chk("ign_hi", 64'(hi), 64'd0);
        chk("ign_lo", 64'(lo), 64'd42);
        chk("ign_done_count", 64'(done_cnt), 64'd1);

        // Reset in the middle of CALC.
        run_op('{op: 3'd6, a: 32'h55, b: 32'h0, hi: 32'h55, lo: 32'd42}, 100);
        start = 1'b1; op = 3'd0; a = 32'hFFFFFFFD; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        done_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
        chk("rst_mid_no_busy", 64'(busy_cnt), 64'd0);

        // Reset and start together: request dropped.
        run_op('{op: 3'd6, a: 32'h3, b: 32'h0, hi: 32'h3, lo: 32'h0}, 101);
        start = 1'b1; op = 3'd7; a = 32'h7; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_start_hi", 64'(hi), 64'd0);
        chk("rst_start_lo", 64'(lo), 64'd0);
        chk("rst_start_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        chk("rst_start_done2", 64'(done), 64'd0);
        chk("rst_start_lo2", 64'(lo), 64'd0);
        start = 1'b1; op = 3'd1; a = 32'h9; b = 32'h9; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_start_mul_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("rst_start_mul_busy2", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
